// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic sensor conditioning stage and the light controller's bench.
// Channel state encodings, default timing parameters and a small width helper.
package traffic_pkg;

  localparam int unsigned CH_STATE_W = 3;

  localparam logic [CH_STATE_W-1:0] CH_CLEAR   = 3'd0;
  localparam logic [CH_STATE_W-1:0] CH_QUAL    = 3'd1;
  localparam logic [CH_STATE_W-1:0] CH_PRESENT = 3'd2;
  localparam logic [CH_STATE_W-1:0] CH_HOLD    = 3'd3;
  localparam logic [CH_STATE_W-1:0] CH_FAULT   = 3'd4;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_HOLD_CYCLES     = 8;
  localparam int unsigned DEF_STUCK_CYCLES    = 1024;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sensor_channel.sv
// One loop-detector channel: 2-flop synchroniser, debounce, gap-hold and stuck-sensor detection.
// Outputs are registered decodes of the next state and fail safe to "traffic present".
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sense,
  input  logic fault_clr,
  output logic t,
  output logic fault
);

  localparam int unsigned CNT_W   = $clog2(max_u(DEBOUNCE_CYCLES, HOLD_CYCLES) + 1);
  localparam int unsigned STUCK_W = $clog2(STUCK_CYCLES + 1);

  logic                  sync1_q, sync2_q;
  logic [CH_STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STUCK_W-1:0]    stuck_q, stuck_d;
  logic                  t_q, t_d;
  logic                  fault_q, fault_d;

  // Next-state logic; every limit compare leaves its state, so counters never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stuck_d = stuck_q;
    case (state_q)
      CH_CLEAR: begin
        if (sync2_q) begin
          state_d = CH_QUAL;
          cnt_d   = CNT_W'(1);
        end
      end
      CH_QUAL: begin
        if (!sync2_q) begin
          state_d = CH_CLEAR;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
          state_d = CH_PRESENT;
          stuck_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CH_PRESENT: begin
        if (!sync2_q) begin
          state_d = CH_HOLD;
          cnt_d   = '0;
        end else if (stuck_q == STUCK_W'(STUCK_CYCLES - 1)) begin
          state_d = CH_FAULT;
        end else begin
          stuck_d = stuck_q + STUCK_W'(1);
        end
      end
      CH_HOLD: begin
        if (sync2_q) begin
          state_d = CH_PRESENT;
          stuck_d = '0;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = CH_CLEAR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CH_FAULT: begin
        if (fault_clr && !sync2_q) begin
          state_d = CH_CLEAR;
        end
      end
      default: begin
        state_d = CH_HOLD;
        cnt_d   = '0;
      end
    endcase
    t_d     = (state_d == CH_PRESENT) || (state_d == CH_HOLD) || (state_d == CH_FAULT);
    fault_d = (state_d == CH_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= CH_HOLD;
      cnt_q   <= '0;
      stuck_q <= '0;
      t_q     <= 1'b1;
      fault_q <= 1'b0;
    end else begin
      sync1_q <= sense;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stuck_q <= stuck_d;
      t_q     <= t_d;
      fault_q <= fault_d;
    end
  end

  assign t     = t_q;
  assign fault = fault_q;

endmodule

// File: rtl/traffic_sensor_cond.sv
// Conditions the street A/B loop detectors into the Ta/Tb inputs of the light controller.
// Two identical, independent channels; this level is wiring only.
module traffic_sensor_cond
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sense_a,
  input  logic sense_b,
  input  logic fault_clr,
  output logic Ta,
  output logic Tb,
  output logic fault_a,
  output logic fault_b
);

  sensor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_chan_a (
    .clk       (clk),
    .reset     (reset),
    .sense     (sense_a),
    .fault_clr (fault_clr),
    .t         (Ta),
    .fault     (fault_a)
  );

  sensor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_chan_b (
    .clk       (clk),
    .reset     (reset),
    .sense     (sense_b),
    .fault_clr (fault_clr),
    .t         (Tb),
    .fault     (fault_b)
  );

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Directed bench for traffic_sensor_cond: per-cycle expected {Ta,Tb,fault_a,fault_b} through a queue.
// Step n counts edges after an input change; the FSM first sees a change on step 3.
module tb_traffic_sensor_cond;

  logic clk = 1'b0;
  logic reset, sense_a, sense_b, fault_clr;
  logic Ta, Tb, fault_a, fault_b;

  logic [3:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_sensor_cond dut (
    .clk       (clk),
    .reset     (reset),
    .sense_a   (sense_a),
    .sense_b   (sense_b),
    .fault_clr (fault_clr),
    .Ta        (Ta),
    .Tb        (Tb),
    .fault_a   (fault_a),
    .fault_b   (fault_b)
  );

  task automatic step(input string name, input logic ta, input logic tb, input logic fa, input logic fb);
    logic [3:0] e;
    logic [3:0] o;
    exp_q.push_back({ta, tb, fa, fb});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = {Ta, Tb, fault_a, fault_b};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got Ta,Tb,fa,fb=%b want %b", name, o, e);
    end
  endtask

  initial begin
    reset = 1'b1; sense_a = 1'b0; sense_b = 1'b0; fault_clr = 1'b0;
    #1;
    step("reset0", 1, 1, 0, 0);
    step("reset1", 1, 1, 0, 0);

    // After release both channels sit in HOLD for HOLD_CYCLES, then follow the idle sensors.
    reset = 1'b0;
    for (int n = 1; n <= 10; n++) step("rst_hold", n < 8, n < 8, 0, 0);

    for (int n = 1; n <= 10; n++) begin
      sense_a = 1'b1;
      step("qualify", n >= 7, 0, 0, 0);
    end

    // Short gap is bridged; long gap drops Ta after HOLD_CYCLES.
    for (int n = 1; n <= 12; n++) begin
      sense_a = (n > 5);
      step("gap_short", 1, 0, 0, 0);
    end
    sense_a = 1'b0;
    for (int n = 1; n <= 20; n++) step("gap_long", n < 11, 0, 0, 0);

    // B pulses of 3 and 4 cycles are rejected; 5 qualifies, then holds.
    for (int len = 3; len <= 5; len++) begin
      for (int n = 1; n <= 20; n++) begin
        sense_b = (n <= len);
        step("glitch", 0, (len >= 5) && (n >= 7) && (n < len + 11), 0, 0);
      end
    end

    // Stuck sensor: fault after STUCK_CYCLES in PRESENT; clear while high is ignored.
    sense_a = 1'b1;
    for (int n = 1; n <= 1100; n++) begin
      fault_clr = (n == 1045);
      step("stuck", n >= 7, 0, n >= 1031, 0);
    end
    fault_clr = 1'b0;

    sense_a = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      fault_clr = (n == 3);
      step("fault_clr", n < 3, 0, n < 3, 0);
    end
    fault_clr = 1'b0;

    // A back to FAULT while B is mid-qualification, then reset with fault_clr held.
    sense_a = 1'b1;
    for (int n = 1; n <= 1035; n++) begin
      sense_b = (n >= 1030);
      step("refault", n >= 7, 0, n >= 1031, 0);
    end
    reset = 1'b1; fault_clr = 1'b1;
    step("rst_mid", 1, 1, 0, 0);

    reset = 1'b0; fault_clr = 1'b0; sense_a = 1'b0; sense_b = 1'b0;
    for (int n = 1; n <= 10; n++) step("rst_mid_hold", n < 8, n < 8, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
